// File: rtl/sram_bus_adapter_if.sv
// sram_bus_if: request/response bus and SRAM port bundle for sram_bus_adapter.
interface sram_bus_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  sram_cs;
    logic                  sram_we;
    logic [3:0]            sram_be;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_din;
    logic [31:0]           sram_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, sram_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, sram_cs, sram_we, sram_be, sram_addr, sram_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, sram_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, sram_cs, sram_we, sram_be, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_bus_adapter.sv
// sram_bus_adapter: byte/half/word load-store bus onto a 32-bit word SRAM.
// Define SRAM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them down.
module sram_bus_adapter #(
    parameter int ADDR_WIDTH = 10
) (
    input logic       clk,
    input logic       rst_n,
    sram_bus_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;
    state_t      state, state_nx;
    logic        accept, err, misalign, cs;
    logic [1:0]  off, lane, size;
    logic        uns, we, rerr;
    logic [31:0] shifted, fmt, rdata;

    assign bus.req_ready = rst_n & (state == IDLE);
    assign accept = bus.req_valid & bus.req_ready;
`ifdef SRAM_MISALIGN_TRAP_EN
    assign misalign = (bus.req_size == 2'b01 & bus.req_addr[0]) | (bus.req_size == 2'b10 & |bus.req_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif
    assign err = (bus.req_size == 2'b11) | (|bus.req_addr[31:ADDR_WIDTH+2]) | misalign;
    assign cs = accept & ~err;
    // Lane offset already aligned down, so misaligned half/word accesses land on their natural lanes
    assign off = bus.req_size == 2'b00 ? bus.req_addr[1:0] :
                 bus.req_size == 2'b01 ? {bus.req_addr[1], 1'b0} : 2'b00;

    assign bus.sram_cs = cs;
    assign bus.sram_we = cs & bus.req_we;
    assign bus.sram_addr = cs ? bus.req_addr[ADDR_WIDTH+1:2] : '0;
    assign bus.sram_be = !cs ? 4'b0000 :
                         bus.req_size == 2'b00 ? 4'b0001 << off :
                         bus.req_size == 2'b01 ? 4'b0011 << off : 4'b1111;
    assign bus.sram_din = !cs ? 32'h0 :
                          bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                          bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;

    assign shifted = bus.sram_dout >> {lane, 3'b000};
    assign fmt = we ? 32'h0 :
                 size == 2'b00 ? {{24{~uns & shifted[7]}}, shifted[7:0]} :
                 size == 2'b01 ? {{16{~uns & shifted[15]}}, shifted[15:0]} : shifted;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (err ? RESP : CAPT) : IDLE;
            CAPT:    state_nx = RESP;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lane  <= 2'b00;
            size  <= 2'b00;
            uns   <= 1'b0;
            we    <= 1'b0;
            rdata <= 32'h0;
            rerr  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lane  <= off;
                size  <= bus.req_size;
                uns   <= bus.req_unsigned;
                we    <= bus.req_we;
                rdata <= 32'h0;
                rerr  <= err;
            end else if (state == CAPT) begin
                rdata <= fmt;
            end
        end
    end

    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err = rerr;
endmodule

// File: tb/tb_sram_bus_adapter.sv
// tb_sram_bus_adapter: directed load/store vectors against a behavioural SRAM.
module tb_sram_bus_adapter;
    localparam int AW = 10;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    sram_bus_if #(.ADDR_WIDTH(AW)) bus ();
    sram_bus_adapter #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (bus.sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.sram_be[i]) mem[bus.sram_addr][8*i +: 8] <= bus.sram_din[8*i +: 8];
            end else begin
                bus.sram_dout <= mem[bus.sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err,
                        input logic [3:0] exp_be, input logic [31:0] exp_addr, input logic [31:0] exp_din,
                        input logic [31:0] exp_rdata);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        #1;
        check({tag, ".cs"}, bus.sram_cs, !exp_err);
        check({tag, ".we"}, bus.sram_we, we & !exp_err);
        check({tag, ".be"}, bus.sram_be, exp_be);
        check({tag, ".addr"}, bus.sram_addr, exp_addr);
        if (we) check({tag, ".din"}, bus.sram_din, exp_din);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom);
        bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        if (!exp_err) begin
            @(negedge clk);
            check({tag, ".capt_valid"}, bus.rsp_valid, 1'b0);
        end
        @(negedge clk);
        check({tag, ".rsp_valid"}, bus.rsp_valid, 1'b1);
        check({tag, ".rsp_err"}, bus.rsp_err, exp_err);
        check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, ".idle"}, bus.req_ready, 1'b1);
    endtask

    initial begin
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        #12;
        check("rst.req_ready", bus.req_ready, 1'b0);
        check("rst.rsp_valid", bus.rsp_valid, 1'b0);
        check("rst.cs", bus.sram_cs, 1'b0);
        check("rst.rdata", bus.rsp_rdata, 32'h0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.req_ready", bus.req_ready, 1'b1);

        xact("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 32'd4, 32'hDEADBEEF, 32'h0);
        check("mem4", mem[4], 32'hDEADBEEF);
        xact("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 4'hF, 32'd4, 32'h0, 32'hDEADBEEF);
        xact("st_w2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0000, 1'b0, 4'hF, 32'd4, 32'h80FF0000, 32'h0);
        xact("ld_bs", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 4'b1000, 32'd4, 32'h0, 32'hFFFFFF80);
        xact("ld_bu", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 4'b1000, 32'd4, 32'h0, 32'h00000080);
        xact("ld_hs", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 4'b1100, 32'd4, 32'h0, 32'hFFFF80FF);
        xact("ld_hu", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 4'b1100, 32'd4, 32'h0, 32'h000080FF);
        xact("st_w3", 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, 1'b0, 4'hF, 32'd8, 32'hAAAAAAAA, 32'h0);
        xact("st_h", 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 1'b0, 4'b1100, 32'd8, 32'h12341234, 32'h0);
        xact("ld_w8", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 4'hF, 32'd8, 32'h0, 32'h1234AAAA);
        xact("oob", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 32'h0);
        xact("oob_st", 1'b1, 2'b00, 1'b0, 32'h80000000, 32'h55, 1'b1, 4'h0, 32'd0, 32'h0, 32'h0);
        xact("rsv", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 32'h0);
`ifdef SRAM_MISALIGN_TRAP_EN
        xact("mis_w", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 32'h0);
        xact("mis_h", 1'b1, 2'b01, 1'b0, 32'h21, 32'h5678, 1'b1, 4'h0, 32'd0, 32'h0, 32'h0);
        xact("st_b", 1'b1, 2'b00, 1'b0, 32'h21, 32'h99, 1'b0, 4'b0010, 32'd8, 32'h99999999, 32'h0);
        xact("ld_w8b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 4'hF, 32'd8, 32'h0, 32'h123499AA);
`else
        xact("mis_w", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, 4'hF, 32'd4, 32'h0, 32'h80FF0000);
        xact("mis_h", 1'b1, 2'b01, 1'b0, 32'h21, 32'h5678, 1'b0, 4'b0011, 32'd8, 32'h56785678, 32'h0);
        xact("st_b", 1'b1, 2'b00, 1'b0, 32'h21, 32'h99, 1'b0, 4'b0010, 32'd8, 32'h99999999, 32'h0);
        xact("ld_w8b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 4'hF, 32'd8, 32'h0, 32'h12349978);
`endif

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'b10;
        bus.req_addr = 32'h10;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("hold.valid0", bus.rsp_valid, 1'b1);
        check("hold.rdata0", bus.rsp_rdata, 32'h80FF0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.valid", bus.rsp_valid, 1'b1);
            check("hold.rdata", bus.rsp_rdata, 32'h80FF0000);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("arst.rsp_valid", bus.rsp_valid, 1'b0);
        check("arst.rsp_rdata", bus.rsp_rdata, 32'h0);
        check("arst.rsp_err", bus.rsp_err, 1'b0);
        check("arst.req_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst.rel_ready", bus.req_ready, 1'b1);
        xact("post_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 4'hF, 32'd4, 32'h0, 32'h80FF0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_bus_adapter.md
SRAM_BUS_ADAPTER -- requirements
Module: sram_bus_adapter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the SRAM word-address width (2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL use one clock and an asynchronous, active-low reset; ports in order:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  adapter accepts the request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected, no SRAM write performed.
- sram_cs, sram_we  out  1 each  SRAM chip select and write enable.
- sram_be  out  4  SRAM byte enables.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_din  out  32  SRAM write data.
- sram_dout  in  32  SRAM read data, valid the cycle after cs.

Function
REQ-003 SHALL implement FSM IDLE, CAPT, RESP; req_ready = 1 only in IDLE with rst_n high.
REQ-004 Acceptance = req_valid & req_ready; sram_cs SHALL be 1 combinationally in the accept cycle only, for non-error requests.
REQ-005 sram_we = req_we, sram_addr = req_addr[ADDR_WIDTH+1:2], combinational in the accept cycle; all sram_* outputs are 0 when sram_cs is 0.
REQ-006 Byte lanes: byte be = 0001<<addr[1:0], din = wdata[7:0] x4; half be = 0011<<(2*addr[1]), din = wdata[15:0] x2; word be = 1111, din = wdata.
REQ-007 Error conditions: req_size = 11, or any req_addr[31:ADDR_WIDTH+2] bit set. On error: no cs, go IDLE->RESP, rsp_valid at accept+1, rsp_err = 1, rsp_rdata = 0.
REQ-008 Non-error request: IDLE->CAPT; in CAPT, register the formatted load result; go CAPT->RESP; rsp_valid = 1 at accept+2.
REQ-009 Load formatting: shift sram_dout right by 8*lane offset (the lane latched at accept); extend from bit 7 (byte) or bit 15 (half) per req_unsigned; word passes through.
REQ-010 Store response: rsp_rdata = 0, rsp_err = 0, same timing as load.
REQ-011 RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; on rsp_valid & rsp_ready go IDLE. Next accept no earlier than the following cycle; peak rate is one request per 3 cycles.
REQ-012 Request fields SHALL be latched at accept; later changes to req_* SHALL have no effect on the response.

Reset
REQ-013 rst_n low SHALL immediately force IDLE and set rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, all latched fields = 0, req_ready = 0 and all sram_* outputs = 0.
REQ-014 Reset in CAPT/RESP SHALL discard the response. A store whose cs edge already occurred remains written; no partial write is issued after reset.

Configuration
REQ-015 Macro SRAM_MISALIGN_TRAP_EN: when defined, a misaligned half (addr[0] = 1) or word (addr[1:0] != 0) SHALL be an error per REQ-007.
REQ-016 Without SRAM_MISALIGN_TRAP_EN: misaligned addresses SHALL be aligned down (half ignores addr[0]; word ignores addr[1:0]), the access is performed, and rsp_err = 0.

Verification
REQ-017 Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> sram_addr = 4, be = 1111; load rsp_rdata = 0xDEADBEEF at accept+2.
REQ-018 Byte load addr 0x13, signed, word = 0x80FF0000 -> rsp_rdata = 0xFFFFFF80; same load unsigned -> 0x00000080.
REQ-019 Half store addr 0x22, data 0x1234 over word 0xAAAAAAAA -> be = 1100, din = 0x12341234; word readback = 0x1234AAAA.
REQ-020 Load addr 0x1000 with ADDR_WIDTH = 10 -> no cs; rsp_err = 1, rsp_rdata = 0 at accept+1.
REQ-021 Word load addr 0x12: with macro -> rsp_err = 1, no cs; without macro -> sram_addr = 4, rsp_err = 0.
REQ-022 Hold rsp_ready = 0 for 5 cycles, then pulse rst_n low during RESP -> response stable until reset; rsp_valid = 0 immediately at reset; req_ready = 1 after release.
